instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Fetch stage of the RV32I core.
- Holds the program counter and issues one instruction-memory request at a time.
- Buffers the returned word in an output register, handing instruction, opcode and PC to decode (sign extension, control) over a valid/ready handshake.
- Handles taken-branch/jump redirects, including discarding an in-flight stale response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INST_WIDTH, 32 (from pkg_config), instruction and address width.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address (= pc).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  load new PC (branch/jump taken).
- redirect_pc_i  in  32  redirect target.
- inst_o  out  32  buffered instruction.
- opcode_o  out  7  inst_o[6:0], combinational from the register.
- pc_o  out  32  address of inst_o.
- inst_valid_o  out  1  output register holds an instruction.
- inst_ready_i  in  1  decode accepts the instruction this cycle.

## Operation
- State machine: FETCH, WAIT, DRAIN.
  - FETCH: imem_req_o=1 only if the output register is free (inst_valid_o=0, or inst_valid_o&&inst_ready_i this cycle). On imem_req_o&&imem_gnt_i → WAIT.
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - inst_o<=rdata; pc_o<=pc; inst_valid_o<=1; pc<=pc+4 (mod 2^32, wraps ffff_fffc→0000_0000).
    - → FETCH.
  - DRAIN: imem_req_o=0. On imem_rvalid_i the data is discarded → FETCH.
- Consume: inst_valid_o&&inst_ready_i clears inst_valid_o, unless a load occurs the same cycle; the load wins and inst_valid_o stays 1.
- Redirect has highest priority, any state:
  - pc<=redirect_pc_i; inst_valid_o<=0.
  - From WAIT, or from FETCH with req&&gnt in the same cycle: → DRAIN.
  - From FETCH without grant: stay FETCH.
  - From DRAIN: stay DRAIN. Pc is updated; the pending response is still dropped.
  - Redirect in WAIT with rvalid in the same cycle: response dropped, → FETCH (nothing outstanding).
- Redirect and consume in the same cycle: redirect wins; the instruction counts as consumed and no new one is loaded.
- Only one request is outstanding at any time; responses arrive in order.
- Reset state:
  - state=FETCH; pc=RESET_PC; inst_valid_o=0.
  - inst_o=32'h0000_0013 (NOP), so opcode_o=7'b0010011 (OP_ALUI); pc_o=RESET_PC.
  - imem_req_o=1 in the first cycle after reset release.

## Timing
- imem_addr_o and imem_req_o are combinational from the registers (pc, state, inst_valid_o) and from inst_ready_i.
- Minimum latency with grant and rvalid each one cycle after request:
  - request cycle N;
  - rvalid N+1;
  - inst_valid_o=1 at N+2.
- Peak throughput: one instruction per 2 cycles.
- Outputs are registered except opcode_o and imem_req_o. inst_o, opcode_o and pc_o stay stable while inst_valid_o=1 and inst_ready_i=0.
- Reset mid-operation: immediate return to reset state. A memory response arriving after rst_i deassert with no request issued since is a protocol violation and is not handled.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - Adds output fetch_misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]≠2'b00 sets fetch_misalign_o=1 and blocks further requests (imem_req_o=0) until reset. Any outstanding response is still drained.
- Not defined: redirect_pc_i[1:0] is ignored and pc[1:0] is forced to 2'b00. No extra port.

## Test plan
- Reset with RESET_PC=0, gnt=1, 1-cycle rvalid latency, memory returns 0x000170b7 @0, 0x0e80026f @4, inst_ready_i=1 → imem_addr_o 0x0 then 0x4. inst_o=0x000170b7 with pc_o=0, then 0x0e80026f with pc_o=4, opcode_o=0110111 then 1101111.
- inst_ready_i=0 for 5 cycles after first valid → inst_o stays 0x000170b7, no second request. Ready=1 → request addr 0x4 issued in the same cycle.
- Redirect to 0x100 in WAIT, stale rvalid data 0xdeadbeef next cycle → 0xdeadbeef never appears on inst_o. Next request addr=0x100.
- Redirect to 0x200 coinciding with consume and with req&&gnt → inst_valid_o=0, DRAIN entered, next request addr=0x200.
- RESET_PC=32'hffff_fffc → fetch at 0xffff_fffc, next request addr 0x0000_0000.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 → fetch_misalign_o=1, imem_req_o held 0. Reset clears the flag, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage. Holds the PC, issues one imem request
// at a time, buffers the returned word for decode over a valid/ready
// handshake, and drops responses made stale by a redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds fetch_misalign_o and
// halts fetching after a redirect to a non-word-aligned target).
module instruction_fetch #(
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [INST_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [INST_WIDTH-1:0] redirect_pc_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [6:0]            opcode_o,
  output logic [INST_WIDTH-1:0] pc_o,
  output logic                  inst_valid_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  fetch_misalign_o,
`endif
  input  logic                  inst_ready_i
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [INST_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [INST_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  valid_q, valid_d;
  logic                  blocked;
  logic                  load;
  logic [INST_WIDTH-1:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign blocked          = misalign_q;
  assign redir_tgt        = redirect_pc_i;
  assign fetch_misalign_o = misalign_q;
`else
  assign blocked   = 1'b0;
  // Low bits are meaningless without the check; keep the PC word aligned.
  assign redir_tgt = redirect_pc_i & ~INST_WIDTH'(3);
`endif

  // A response in WAIT is written to the buffer unless a redirect kills it.
  assign load = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= NOP;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next state: a redirect sends any still-outstanding response to DRAIN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (imem_req_o && imem_gnt_i) state_d = redirect_i ? S_DRAIN : S_WAIT;
      S_WAIT:  if (imem_rvalid_i)            state_d = S_FETCH;
               else if (redirect_i)          state_d = S_DRAIN;
      S_DRAIN: if (imem_rvalid_i)            state_d = S_FETCH;
      default:                               state_d = S_FETCH;
    endcase
  end

  // Outputs: request only when the buffer is free or being emptied this cycle
  always_comb begin
    imem_req_o   = (state_q == S_FETCH) && (!valid_q || inst_ready_i) && !blocked;
    imem_addr_o  = pc_q;
    inst_o       = inst_q;
    opcode_o     = inst_q[6:0];
    pc_o         = pc_out_q;
    inst_valid_o = valid_q;
  end

  // Datapath next values: redirect > load > consume
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (redirect_i) begin
      pc_d    = redir_tgt;
      valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
`endif
    end else if (load) begin
      inst_d   = imem_rdata_i;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + INST_WIDTH'(4);
    end else if (valid_q && inst_ready_i) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random stimulus for instruction_fetch,
// checked against a transaction-level model (outstanding request, stale flag,
// decode buffer). A second instance covers PC wrap from RESET_PC=ffff_fffc.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid, redirect, ready, valid;
  logic [31:0] addr, rdata, redirect_pc, inst, pc_out;
  logic [6:0]  opcode;
  logic        req2, gnt2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, inst2, pc2;
  logic [6:0]  op2;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        mis, mis2;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .inst_o(inst),
    .opcode_o(opcode), .pc_o(pc_out), .inst_valid_o(valid),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign_o(mis),
`endif
    .inst_ready_i(ready));

  instruction_fetch #(.RESET_PC(32'hffff_fffc)) u_wrap (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(gnt2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .inst_o(inst2),
    .opcode_o(op2), .pc_o(pc2), .inst_valid_o(valid2),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign_o(mis2),
`endif
    .inst_ready_i(1'b1));

  // reference model state
  logic [31:0] m_pc, m_binst, m_bpc;
  bit          m_out, m_stale, m_bv, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0001_70b7;
    if (a == 32'h4) return 32'h0e80_026f;
    return (a * 32'h9e37_79b1) ^ 32'h13;
  endfunction

  task automatic do_reset();
    rst = 1'b1; gnt = 0; rvalid = 0; rdata = 0; redirect = 0; redirect_pc = 0; ready = 0;
    gnt2 = 0; rvalid2 = 0; rdata2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_binst = 32'h13; m_bpc = 0; m_out = 0; m_stale = 0; m_bv = 0; m_mis = 0;
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_pc_o", pc_out, 0);
    chk("rst_req", 32'(req), 1);
    chk("rst_addr", addr, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(mis), 0);
`endif
  endtask

  // One cycle: drive inputs, compare DUT to model, advance model over the edge.
  task automatic cyc(input bit g, input bit rv, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit exp_req, granted, rvv, cons;
    @(negedge clk);
    gnt = g; ready = rdy; redirect = rd; redirect_pc = rpc;
    rvv = m_out && rv;
    rvalid = rvv;
    rdata = m_stale ? 32'hdead_beef : mem(m_pc);
    #1;
    exp_req = !m_out && (!m_bv || rdy) && !m_mis;
    chk("req", 32'(req), 32'(exp_req));
    chk("addr", addr, m_pc);
    chk("valid", 32'(valid), 32'(m_bv));
    chk("inst", inst, m_binst);
    chk("opcode", 32'(opcode), 32'(m_binst[6:0]));
    chk("pc_o", pc_out, m_bpc);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign", 32'(mis), 32'(m_mis));
`endif
    granted = exp_req && g;
    cons    = m_bv && rdy;
    if (rd) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) m_mis = 1;
      m_pc = rpc;
`else
      m_pc = rpc & ~32'd3;
`endif
      m_bv = 0;
      if (rvv) m_out = 0;
      else if (m_out || granted) begin m_out = 1; m_stale = 1; end
    end else if (rvv) begin
      m_out = 0;
      if (!m_stale) begin
        m_binst = rdata; m_bpc = m_pc; m_bv = 1; m_pc = m_pc + 32'd4;
      end else if (cons) m_bv = 0;
      m_stale = 0;
    end else begin
      if (cons) m_bv = 0;
      if (granted) begin m_out = 1; m_stale = 0; end
    end
  endtask

  initial begin
    do_reset();

    // PC wrap on the second instance; main DUT idles without a grant.
    cyc(0, 0, 1, 0, 0);
    chk("wrap_req", 32'(req2), 1);
    chk("wrap_addr0", addr2, 32'hffff_fffc);
    gnt2 = 1;
    cyc(0, 0, 1, 0, 0);
    gnt2 = 0; rvalid2 = 1; rdata2 = 32'h0000_0013;
    cyc(0, 0, 1, 0, 0);
    rvalid2 = 0;
    chk("wrap_valid", 32'(valid2), 1);
    chk("wrap_pc_o", pc2, 32'hffff_fffc);
    chk("wrap_req2", 32'(req2), 1);
    chk("wrap_addr1", addr2, 32'h0);

    // First fetch, then decode stalls for 5 cycles.
    cyc(1, 0, 1, 0, 0);
    chk("first_addr", addr, 32'h0);
    cyc(0, 1, 0, 0, 0);
    repeat (5) begin
      cyc(1, 0, 0, 0, 0);
      chk("stall_inst", inst, 32'h0001_70b7);
      chk("stall_noreq", 32'(req), 0);
    end
    chk("first_opcode", 32'(opcode), 32'b0110111);
    cyc(1, 0, 1, 0, 0);
    chk("ready_req", 32'(req), 1);
    chk("ready_addr", addr, 32'h4);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("second_inst", inst, 32'h0e80_026f);
    chk("second_pc", pc_out, 32'h4);
    chk("second_opcode", 32'(opcode), 32'b1101111);

    // Redirect in WAIT; stale response follows and must be dropped.
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 32'h100);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("drain_valid", 32'(valid), 0);
    chk("redir_addr", addr, 32'h100);

    // Redirect with consume and req&&gnt in the same cycle.
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 32'h200);
    cyc(0, 0, 1, 0, 0);
    chk("rc_valid", 32'(valid), 0);
    chk("rc_drain_noreq", 32'(req), 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("rc_addr", addr, 32'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
    cyc(0, 0, 1, 1, 32'h102);
    repeat (3) cyc(1, 0, 1, 0, 0);
    chk("mis_flag", 32'(mis), 1);
    chk("mis_noreq", 32'(req), 0);
    do_reset();
    chk("mis_cleared", 32'(mis), 0);
`else
    cyc(0, 0, 1, 1, 32'h303);
    cyc(0, 0, 1, 0, 0);
    chk("align_addr", addr, 32'h300);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
          ($urandom % 12) == 0, {$urandom_range(0, 32'h3fff_ffff), 2'b00});
      if (valid && inst == 32'hdead_beef) chk("no_stale", inst, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
